mix_transpose_buf: RTL
======================

# mix_transpose_buf

Row-to-column transpose buffer between consecutive mix-layer `main_src` stages. It collects DIM output rows of one stage, each DIM words wide, into a DIM×DIM register array. It then replays the array column by column, so the next stage mixes along the other axis (token mixing ↔ channel mixing). It is a single buffer: filling and draining never overlap.

## Interface
Parameters:
- `DIM`, default `` `HID_DIM ``: matrix side; words per row and column, and rows per matrix.
- `N_LEN`, default `` `N_LEN ``: bits per word (two's-complement fixed point; passed through untouched).

Ports:
- `clk`  in  1  single clock; everything is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `clear`  in  1  synchronous abort. Discards the partial matrix and returns to FILL, row 0.
- `in_valid`  in  1  upstream row strobe (the `valid` of the upstream stage).
- `in_data`  in  DIM*N_LEN  upstream row. Word k sits at `[k*N_LEN +: N_LEN]`.
- `in_ready`  out  1  high in FILL.
- `out_valid`  out  1  a column is presented (DRAIN).
- `out_ready`  in  1  downstream accepts the column.
- `out_data`  out  DIM*N_LEN  column c. Word r = row r, word c of the stored matrix.
- `out_last`  out  1  high with `out_valid` on column DIM-1.
- `overflow`  out  1  sticky: a row arrived while not ready.

## Operation
- The FSM has two states, FILL and DRAIN. Counters `row` and `col` are each clog2(DIM) bits, minimum 1.
- FILL:
  - `in_ready`=1, `out_valid`=0.
  - On `in_valid`, `in_data` is written to array row `row`, and `row` increments.
  - On the accept with `row`==DIM-1: `row`←0, `col`←0, next state DRAIN.
- DRAIN:
  - `in_ready`=0, `out_valid`=1.
  - `out_data` is a pure mux of the array indexed by `col`, so it stays stable while stalled.
  - A handshake (`out_valid`&&`out_ready`) increments `col`.
  - The handshake at `col`==DIM-1 returns to FILL with `col`←0.
- `in_valid` seen in DRAIN:
  - The row is dropped and `overflow`←1.
  - The array, counters and state are unchanged.
  - The upstream stage has no backpressure, so the system scheduler must not issue `run` while draining. `overflow` is the debug indicator for that violation.
- `clear`:
  - Next state FILL; `row`←0, `col`←0.
  - `overflow` is also cleared.
  - The array contents are not cleared; stale data is never output because a full refill is required first.
  - Priority: `rst` > `clear` > `in_valid`/handshake in the same cycle.
- No arithmetic, widening or rounding. Words are copied bit-exact.

## Timing
- Reset values: state FILL, `row`=0, `col`=0, `in_ready`=1, `out_valid`=0, `out_last`=0, `overflow`=0.
  - `out_data` is don't-care while `out_valid`=0. Array registers are not reset.
- Latency:
  - The last row accepted at cycle t gives `out_valid`=1 with column 0 at t+1.
  - With `out_ready` held high, columns 0..DIM-1 appear on t+1..t+DIM.
  - `in_ready`=1 again at t+DIM+1.
- Throughput with no stalls: one matrix per 2·DIM cycles.
- `out_ready` low holds `col`, `out_data` and `out_last` unchanged indefinitely.
- Back-to-back `in_valid` on consecutive cycles in FILL are all accepted.
- Wrap-around: the `row` and `col` counters wrap at DIM-1 to 0, never at a power of 2. This applies when DIM is not a power of 2.
- `rst` or `clear` asserted mid-DRAIN:
  - `out_valid` is 0 on the next cycle.
  - The partially drained matrix is lost.
  - `in_ready` is 1 on the next cycle.

## Test plan
Bench uses DIM=4, N_LEN=8; word (r,c) = 8'h{r}{c}.
- Reset then idle → `in_ready`=1, `out_valid`=0, `overflow`=0. Then 4 rows on consecutive cycles with `out_ready`=1 → one cycle later columns {00,10,20,30}, {01,11,21,31}, {02,…}, {03,13,23,33} on 4 consecutive cycles. `out_last` only on the 4th. `in_ready`=1 on the following cycle.
- Stall: hold `out_ready`=0 for 5 cycles on column 1, then release → column 1 value and `out_last`=0 stay constant while stalled. Column 2 appears one cycle after release.
- Overflow: pulse `in_valid` with 8'hFF words during DRAIN → drained columns are unchanged, `overflow`=1 and sticky. `clear` → `overflow`=0.
- Gapped input: rows separated by 3 idle cycles → identical column output. `out_valid` rises exactly one cycle after the 4th row.
- Abort: `clear` after 2 rows, then 4 new rows (r,c)+8'h40 → output contains only the new matrix.
- `rst` mid-DRAIN at column 2 → next cycle `out_valid`=0, `in_ready`=1. A subsequent full fill drains correctly.

Source files
------------

// File: rtl/mix_transpose_buf.sv
// mix_transpose_buf: collects DIM rows into a DIMxDIM array, then replays it column by column.
`ifndef HID_DIM
`define HID_DIM 4
`endif
`ifndef N_LEN
`define N_LEN 8
`endif
module mix_transpose_buf #(
  parameter int DIM   = `HID_DIM,
  parameter int N_LEN = `N_LEN
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 in_valid,
  input  logic [DIM*N_LEN-1:0] in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DIM*N_LEN-1:0] out_data,
  output logic                 out_last,
  output logic                 overflow
);
  localparam int CW = DIM > 1 ? $clog2(DIM) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIM - 1);
  typedef enum logic {FILL, DRAIN} state_t;
  state_t state, state_n;
  logic [CW-1:0] row, col, row_n, col_n;
  logic [N_LEN-1:0] mem [DIM][DIM];
  logic accept, shake;
  assign in_ready  = state == FILL;
  assign out_valid = state == DRAIN;
  assign out_last  = out_valid && col == LAST;
  assign accept    = in_ready && in_valid;
  assign shake     = out_valid && out_ready;
  always_comb begin
    out_data = '0;
    for (int r = 0; r < DIM; r++) out_data[r*N_LEN +: N_LEN] = mem[r][col];
  end
  always_comb begin
    state_n = state;
    row_n   = row;
    col_n   = col;
    if (clear) begin
      state_n = FILL;
      row_n   = '0;
      col_n   = '0;
    end else if (accept) begin
      row_n   = row == LAST ? '0 : row + 1'b1;
      col_n   = row == LAST ? '0 : col;
      state_n = row == LAST ? DRAIN : FILL;
    end else if (shake) begin
      col_n   = col == LAST ? '0 : col + 1'b1;
      state_n = col == LAST ? FILL : DRAIN;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FILL;
      row      <= '0;
      col      <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_n;
      row      <= row_n;
      col      <= col_n;
      overflow <= clear ? 1'b0 : (overflow || (out_valid && in_valid));
    end
  end
  // The array has no reset; a full refill always precedes any drain.
  always_ff @(posedge clk) begin
    if (!rst && !clear && accept)
      for (int k = 0; k < DIM; k++) mem[row][k] <= in_data[k*N_LEN +: N_LEN];
  end
endmodule
